// File: rtl/div_pkg.sv
// Shared types and defaults for the shift-subtract divider.
package div_pkg;

    localparam int DEF_N  = 4;
    localparam int DEF_KW = $clog2(DEF_N + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SHIFT,
        S_SUB,
        S_DONE
    } state_t;

endpackage

// File: rtl/shift_sub_divider_if.sv
// Start/result bundle between a datapath controller and the divider.
interface shift_sub_divider_if #(
    parameter int N = 4
);
    logic           St;
    logic [2*N-1:0] Dividend;
    logic [N-1:0]   Divisor;
    logic [N-1:0]   Quotient;
    logic [N-1:0]   Remainder;
    logic           V;
    logic           Idle;
    logic           Done;

    modport master (
        output St, Dividend, Divisor,
        input  Quotient, Remainder, V, Idle, Done
    );

    modport slave (
        input  St, Dividend, Divisor,
        output Quotient, Remainder, V, Idle, Done
    );
endinterface

// File: rtl/div_control.sv
// Divider sequencer: IDLE/CHECK/SHIFT/SUB/DONE with the iteration counter.
module div_control
    import div_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int KW = DEF_KW
) (
    input  logic Clk,
    input  logic Rst,
    input  logic St,
    input  logic C,
    output logic Load,
    output logic Sh,
    output logic Su,
    output logic Ovf,
    output logic Idle,
    output logic Done
);
    localparam logic [KW-1:0] K_LAST = KW'(N);

    state_t        state;
    logic [KW-1:0] k;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= S_IDLE;
            k     <= '0;
            Idle  <= 1'b1;
            Done  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (St) begin
                        state <= S_CHECK;
                        k     <= '0;
                        Idle  <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (C) begin
                        state <= S_DONE;
                        Done  <= 1'b1;
                    end else begin
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    k     <= k + KW'(1);
                    state <= S_SUB;
                end
                S_SUB: begin
                    if (k == K_LAST) begin
                        state <= S_DONE;
                        Done  <= 1'b1;
                    end else begin
                        state <= S_SHIFT;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    Done  <= 1'b0;
                    Idle  <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    Done  <= 1'b0;
                    Idle  <= 1'b1;
                end
            endcase
        end
    end

    // Datapath strobes act on the same edge that advances the state
    assign Load = (state == S_IDLE) && St;
    assign Ovf  = (state == S_CHECK) && C;
    assign Sh   = (state == S_SHIFT);
    assign Su   = (state == S_SUB) && C;

endmodule

// File: rtl/shift_sub_divider.sv
// Restoring shift-subtract divider: 2N-bit dividend by N-bit divisor.
module shift_sub_divider
    import div_pkg::*;
#(
    parameter int N = DEF_N
) (
    input logic                Clk,
    input logic                Rst,
    shift_sub_divider_if.slave bus
);
    localparam int KW = $clog2(N + 1);

    logic [2*N:0] x;
    logic [N-1:0] d;
    logic         v;
    logic         c;
    logic         load;
    logic         sh;
    logic         su;
    logic         ovf;

    // Upper part includes the shifted-out bit so the compare sees N+1 bits
    assign c = x[2*N:N] >= {1'b0, d};

    div_control #(
        .N  (N),
        .KW (KW)
    ) u_ctrl (
        .Clk  (Clk),
        .Rst  (Rst),
        .St   (bus.St),
        .C    (c),
        .Load (load),
        .Sh   (sh),
        .Su   (su),
        .Ovf  (ovf),
        .Idle (bus.Idle),
        .Done (bus.Done)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            x <= '0;
            d <= '0;
            v <= 1'b0;
        end else if (load) begin
            x <= {1'b0, bus.Dividend};
            d <= bus.Divisor;
            v <= 1'b0;
        end else if (ovf) begin
            v <= 1'b1;
        end else if (sh) begin
            x <= {x[2*N-1:0], 1'b0};
        end else if (su) begin
            x[2*N:N] <= x[2*N:N] - {1'b0, d};
            x[0]     <= 1'b1;
        end
    end

    assign bus.Quotient  = x[N-1:0];
    assign bus.Remainder = x[2*N-1:N];
    assign bus.V         = v;

endmodule
